pc_gen: RTL and testbench

Parametrised fetch-stage program-counter unit for the pipelined MIPS core. It owns the PC register and the next-PC selection:
- sequential fetch, conditional branches, 26-bit jumps and register jumps
- exception-vector entry and `eret` return
- stall hold
- delay-slot (BD) tracking for the exception unit

It also flags fetch address faults (misaligned or outside instruction memory) so the F stage can raise AdEL.

---
 rtl/pc_gen_pkg.sv | 14 +
 rtl/pc_target_calc.sv | 25 ++
 rtl/pc_gen.sv | 92 +++++++++
 tb/tb_pc_gen.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/pc_gen_pkg.sv
// Shared control-transfer codes and default addresses for the fetch PC unit.
// The jump codes are also decoded by the decoder and the hazard unit.
package pc_gen_pkg;

    // Control-transfer kind of the instruction in decode; 3'b1xx is reserved (acts as SEQ)
    localparam logic [2:0] JUMP_SEQ = 3'b000;
    localparam logic [2:0] JUMP_BR  = 3'b001;
    localparam logic [2:0] JUMP_J   = 3'b010;
    localparam logic [2:0] JUMP_JR  = 3'b011;

    localparam logic [31:0] RESET_PC_DEF   = 32'h0000_3000;
    localparam logic [31:0] EXC_VECTOR_DEF = 32'h0000_4180;

endpackage

// File: rtl/pc_target_calc.sv
// Combinational target generator: sequential, branch and 26-bit jump targets.
// All arithmetic is 32-bit modulo; carries out of bit 31 are dropped.
module pc_target_calc (
    input  logic [31:0] pc,
    input  logic [31:0] d_pc,
    input  logic [15:0] imm16,
    input  logic [25:0] bits26,
    output logic [31:0] seq_tgt,
    output logic [31:0] br_tgt,
    output logic [31:0] j_tgt
);

    logic [31:0] d_pc_4;
    logic [31:0] br_off;

    // Branch offset is word-scaled and sign-extended; jumps keep the delay-slot region bits
    always_comb begin
        d_pc_4  = d_pc + 32'd4;
        br_off  = {{14{imm16[15]}}, imm16, 2'b00};
        seq_tgt = pc + 32'd4;
        br_tgt  = d_pc_4 + br_off;
        j_tgt   = {d_pc_4[31:28], bits26, 2'b00};
    end

endmodule

// File: rtl/pc_gen.sv
// Fetch-stage PC register with next-PC priority selection, delay-slot tracking
// and fetch address fault detection. The PC is never forced aligned so the
// faulting address remains visible for BadVAddr.
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
    parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF,
    parameter logic [31:0] IMEM_BASE  = 32'h0000_3000,
    parameter int unsigned IMEM_WORDS = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic [31:0] d_pc,
    input  logic [2:0]  jump,
    input  logic        b_true,
    input  logic [15:0] imm16,
    input  logic [25:0] bits26,
    input  logic [31:0] ra,
    input  logic        exc_req,
    input  logic        eret,
    input  logic [31:0] epc,
    output logic [31:0] pc,
    output logic [31:0] npc,
    output logic        bd,
    output logic        adel
);

    // Last valid word address, computed in 33 bits so a region ending at the top cannot wrap
    localparam logic [32:0] IMEM_LAST = {1'b0, IMEM_BASE} + (33'(IMEM_WORDS) << 2) - 33'd4;

    logic [31:0] seq_tgt;
    logic [31:0] br_tgt;
    logic [31:0] j_tgt;
    logic        bd_nxt;

    pc_target_calc u_tgt (
        .pc      (pc),
        .d_pc    (d_pc),
        .imm16   (imm16),
        .bits26  (bits26),
        .seq_tgt (seq_tgt),
        .br_tgt  (br_tgt),
        .j_tgt   (j_tgt)
    );

    // Next-PC priority: exception, eret, stall, then decode-stage control transfer
    always_comb begin
        npc = seq_tgt;
        if (exc_req)
            npc = EXC_VECTOR;
        else if (eret)
            npc = epc;
        else if (stall)
            npc = pc;
        else if (jump == JUMP_BR && b_true)
            npc = br_tgt;
        else if (jump == JUMP_J)
            npc = j_tgt;
        else if (jump == JUMP_JR)
            npc = ra;
    end

    // Next fetch is a delay slot whenever decode holds any real transfer, taken or not
    always_comb begin
        bd_nxt = 1'b0;
        if (exc_req || eret)
            bd_nxt = 1'b0;
        else if (stall)
            bd_nxt = bd;
        else
            bd_nxt = (jump == JUMP_BR) || (jump == JUMP_J) || (jump == JUMP_JR);
    end

    // PC and delay-slot flag registers; reset overrides every other input
    always_ff @(posedge clk) begin
        if (reset) begin
            pc <= RESET_PC;
            bd <= 1'b0;
        end else begin
            pc <= npc;
            bd <= bd_nxt;
        end
    end

    // Fetch fault: misaligned, below the base, or past the last instruction word
    assign adel = (pc[1:0] != 2'b00)
                | ({1'b0, pc} < {1'b0, IMEM_BASE})
                | ({1'b0, pc} > IMEM_LAST);

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: each step pushes the expected next state to a
// scoreboard, checks the combinational npc before the edge, then pops and
// compares pc/bd/adel after the edge.
module tb_pc_gen;
    import pc_gen_pkg::*;

    typedef struct packed {
        logic [31:0] pc;
        logic        bd;
        logic        adel;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset, stall, b_true, exc_req, eret;
    logic [31:0] d_pc, ra, epc;
    logic [2:0]  jump;
    logic [15:0] imm16;
    logic [25:0] bits26;
    logic [31:0] pc, npc;
    logic        bd, adel;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    pc_gen dut (
        .clk     (clk),
        .reset   (reset),
        .stall   (stall),
        .d_pc    (d_pc),
        .jump    (jump),
        .b_true  (b_true),
        .imm16   (imm16),
        .bits26  (bits26),
        .ra      (ra),
        .exc_req (exc_req),
        .eret    (eret),
        .epc     (epc),
        .pc      (pc),
        .npc     (npc),
        .bd      (bd),
        .adel    (adel)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, got no summary, required finish");
        $fatal(1, "timeout");
    end

    // One clock step: inputs already driven; expectation is the state after the edge
    task automatic step(input string tag, input logic [31:0] e_pc, input logic e_bd,
                        input logic e_adel);
        exp_t e;
        sb.push_back('{pc: e_pc, bd: e_bd, adel: e_adel});
        #1;
        if (!reset) begin
            tests++;
            assert (npc === e_pc) else begin
                fails++;
                $error("FAIL %s.npc got %h want %h", tag, npc, e_pc);
            end
        end
        @(posedge clk);
        #1;
        e = sb.pop_front();
        tests++;
        assert (pc === e.pc) else begin
            fails++;
            $error("FAIL %s.pc got %h want %h", tag, pc, e.pc);
        end
        tests++;
        assert (bd === e.bd) else begin
            fails++;
            $error("FAIL %s.bd got %b want %b", tag, bd, e.bd);
        end
        tests++;
        assert (adel === e.adel) else begin
            fails++;
            $error("FAIL %s.adel got %b want %b", tag, adel, e.adel);
        end
    endtask

    task automatic idle();
        reset = 0; stall = 0; jump = JUMP_SEQ; b_true = 0; exc_req = 0; eret = 0;
        d_pc = 32'h0; imm16 = 16'h0; bits26 = 26'h0; ra = 32'h0; epc = 32'h0;
    endtask

    initial begin
        idle();
        reset = 1;
        @(negedge clk);
        step("reset", 32'h3000, 0, 0);

        idle();
        step("seq1", 32'h3004, 0, 0);
        step("seq2", 32'h3008, 0, 0);
        step("seq3", 32'h300C, 0, 0);

        // Backward branch: 3010+4-16
        d_pc = 32'h3010; jump = JUMP_BR; b_true = 1; imm16 = 16'hFFFC;
        step("br_taken", 32'h3004, 1, 0);
        b_true = 0;
        step("br_not", 32'h3008, 1, 0);

        idle();
        d_pc = 32'h3000; jump = JUMP_J; bits26 = 26'h0000C10;
        step("j", 32'h3040, 1, 0);

        idle();
        jump = JUMP_JR; ra = 32'h3002;
        step("jr_mis", 32'h3002, 1, 1);

        // Stall with a pending J: pc/bd hold
        idle();
        stall = 1; jump = JUMP_J; d_pc = 32'h3000; bits26 = 26'h0000C10;
        for (int i = 0; i < 4; i++) step("stall", 32'h3002, 1, 1);
        exc_req = 1;
        step("exc_stall", 32'h4180, 0, 0);

        idle();
        eret = 1; epc = 32'h3100; jump = JUMP_BR; b_true = 1; d_pc = 32'h3010; imm16 = 16'h0010;
        step("eret_br", 32'h3100, 0, 0);
        exc_req = 1;
        step("exc_eret", 32'h4180, 0, 0);

        // Range edges via JR
        idle();
        jump = JUMP_JR; ra = 32'h2FFC;
        step("lo_edge", 32'h2FFC, 1, 1);
        ra = 32'h6FFC;
        step("hi_last", 32'h6FFC, 1, 0);
        ra = 32'h7000;
        step("hi_past", 32'h7000, 1, 1);

        // Reserved code acts as SEQ with bd=0
        idle();
        jump = 3'b110;
        step("reserved", 32'h7004, 0, 1);

        // Wrap at top of address space
        idle();
        jump = JUMP_JR; ra = 32'hFFFF_FFFC;
        step("top", 32'hFFFF_FFFC, 1, 1);
        idle();
        step("wrap", 32'h0000_0000, 0, 1);

        // Reset wins over exc_req
        idle();
        reset = 1; exc_req = 1;
        step("rst_exc", 32'h3000, 0, 0);

        idle();
        step("post_rst", 32'h3004, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
